// File: rtl/rmgmt_ext_decode_if.sv
// rtl/rmgmt_ext_decode_if.sv - RISC-MGMT decode-stage interface between core and extension
interface rmgmt_ext_decode_if;
    logic [31:0] insn;
    logic        insn_valid;
    logic        stall;
    logic        flush;
    logic        insn_claim;
    logic        bubble_req;
    logic [4:0]  rsel_s_0;
    logic [4:0]  rsel_s_1;
    logic [4:0]  rsel_d;

    // Core side: presents the decode-stage instruction and pipeline control
    modport master (
        output insn, insn_valid, stall, flush,
        input  insn_claim, bubble_req, rsel_s_0, rsel_s_1, rsel_d
    );

    // Extension side: claims custom instructions and raises hazards
    modport slave (
        input  insn, insn_valid, stall, flush,
        output insn_claim, bubble_req, rsel_s_0, rsel_s_1, rsel_d
    );
endinterface

// File: rtl/rmgmt_ext_decode.sv
// rtl/rmgmt_ext_decode.sv - extension decode unit: claim, hazard bubbles, single in-flight op tracking
module rmgmt_ext_decode #(
    parameter logic [6:0] OPCODE  = 7'b0001011,
    parameter int         LATENCY = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    rmgmt_ext_decode_if.slave    bus,
    output logic                 dec_valid,
    output logic [2:0]           dec_funct3,
    output logic [6:0]           dec_funct7,
    output logic [4:0]           dec_rd,
    output logic                 done,
    output logic [4:0]           done_rd
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [4:0] busy_rd;
    logic       match;
    logic       raw_hit;
    logic       accept;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign rs1   = bus.insn[19:15];
    assign rs2   = bus.insn[24:20];
    assign rd    = bus.insn[11:7];
    assign match = bus.insn_valid & (bus.insn[6:0] == OPCODE);

    // RAW check is format-agnostic: any valid instruction whose source fields hit the tracked rd
    assign raw_hit = bus.insn_valid & (busy_rd != 5'd0) & ((rs1 == busy_rd) | (rs2 == busy_rd));

    assign bus.insn_claim = match;
    assign bus.rsel_s_0   = match ? rs1 : 5'd0;
    assign bus.rsel_s_1   = match ? rs2 : 5'd0;
    assign bus.rsel_d     = match ? rd  : 5'd0;
    assign done_rd        = done ? busy_rd : 5'd0;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: leave BUSY on the edge that ends the done cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (cnt == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: hazards only exist while an operation is in flight
    always_comb begin
        bus.bubble_req = 1'b0;
        done           = 1'b0;
        if (state == BUSY) begin
            bus.bubble_req = match | raw_hit;
            done           = (cnt == 4'd1);
        end
        accept = match & ~bus.bubble_req & ~bus.stall & ~bus.flush;
    end

    // Countdown and tracked destination; runs regardless of stall/flush
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt     <= 4'd0;
            busy_rd <= 5'd0;
        end else if (accept) begin
            cnt     <= LAT;
            busy_rd <= rd;
        end else if (state == BUSY) begin
            cnt     <= cnt - 4'd1;
        end
    end

    // Registered issue port; fields hold until the next accept
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dec_valid  <= 1'b0;
            dec_funct3 <= 3'd0;
            dec_funct7 <= 7'd0;
            dec_rd     <= 5'd0;
        end else begin
            dec_valid <= accept;
            if (accept) begin
                dec_funct3 <= bus.insn[14:12];
                dec_funct7 <= bus.insn[31:25];
                dec_rd     <= rd;
            end
        end
    end
endmodule

// File: doc/rmgmt_ext_decode.md
Name: rmgmt_ext_decode

Overview:
- Extension-side decode unit: the driving (ext) end of the RISC-MGMT decode interface (insn_claim, bubble_req, rsel_s_0, rsel_s_1, rsel_d).
- Claims custom-opcode instructions in the decode stage and supplies register selects to RISC-MGMT.
- Tracks one in-flight fixed-latency custom operation; requests bubbles on structural and RAW hazards against it.
- Hands accepted instructions to the extension execute stage through a registered issue port.

Parameters:
- OPCODE, 7'b0001011, major opcode claimed (custom-0).
- LATENCY, 4, execute cycles per claimed instruction; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- insn  input  32  instruction word currently in decode.
- insn_valid  input  1  insn is valid this cycle.
- stall  input  1  pipeline stall; decode does not advance.
- flush  input  1  kill the instruction in decode.
- insn_claim  output  1  insn matches OPCODE (ext-side interface).
- bubble_req  output  1  hazard; decode must insert a bubble (ext-side interface).
- rsel_s_0  output  5  rs1 select (ext-side interface).
- rsel_s_1  output  5  rs2 select (ext-side interface).
- rsel_d  output  5  rd select (ext-side interface).
- dec_valid  output  1  one-cycle issue pulse to execute.
- dec_funct3  output  3  registered insn[14:12].
- dec_funct7  output  7  registered insn[31:25].
- dec_rd  output  5  registered rd of the issued instruction.
- done  output  1  in-flight operation completes this cycle.
- done_rd  output  5  rd of the completing operation.

Behaviour:
- Combinational decode:
  - match = insn_valid & (insn[6:0] == OPCODE).
  - insn_claim = match.
  - rsel_s_0 = insn[19:15], rsel_s_1 = insn[24:20], rsel_d = insn[11:7] when match; all 0 otherwise.
- Accept = match & ~bubble_req & ~stall & ~flush. Only one operation may be in flight.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on accept: busy_rd <= insn[11:7], cnt <= LATENCY; dec_valid, dec_funct3, dec_funct7, dec_rd registered on the same edge.
  - BUSY: cnt decrements every cycle, independent of stall and flush.
  - done = 1 and done_rd = busy_rd in the BUSY cycle where cnt == 1.
  - BUSY -> IDLE on the edge after done.
  - Timeline: accept in cycle T; dec_valid high in T+1; done high in T+LATENCY; a new accept is possible in T+LATENCY+1 at the earliest.
- bubble_req is combinational and is 0 in IDLE. In BUSY it is 1 when either:
  - match (structural: a second custom op while one is in flight, including the done cycle), or
  - insn_valid & busy_rd != 0 & (insn[19:15] == busy_rd | insn[24:20] == busy_rd) (RAW). This check applies to any instruction, custom or base, regardless of format.
- bubble_req ignores stall and flush.
- dec_valid is high exactly one cycle per accept. dec_funct3, dec_funct7 and dec_rd hold their values until the next accept.
- flush kills only the decode-stage instruction (no accept). It never cancels the in-flight operation.
- Reset (asynchronous, any time, including mid-operation):
  - State IDLE, cnt 0, busy_rd 0.
  - dec_valid, dec_funct3, dec_funct7, dec_rd, done and done_rd all 0.
  - Combinational outputs follow the inputs immediately.
- Width rules:
  - cnt is 4 bits.
  - LATENCY == 1: done is high in T+1, the same cycle as dec_valid.
  - rd == x0 is tracked, but never causes a RAW bubble.

Test Plan:
- Claim/decode: insn=32'h00C5_850B, insn_valid=1, IDLE -> insn_claim=1, rsel_s_0=11, rsel_s_1=12, rsel_d=10, bubble_req=0; dec_valid=1 next cycle with dec_rd=10, dec_funct3=0, dec_funct7=0.
- Non-match: insn=32'h00C5_8533 (add) -> insn_claim=0, all rsel=0, no dec_valid.
- RAW timing (LATENCY=4): accept rd=10 at T; base add reading x10 presented T+1..T+5 -> bubble_req=1 for T+1..T+4, done=1 with done_rd=10 at T+4, bubble_req=0 at T+5.
- Structural and x0: custom op presented during BUSY -> bubble_req=1, no second dec_valid. Custom op with rd=0 in flight, add reading x0 -> bubble_req=0.
- Stall/flush: stall=1 with a matching insn in IDLE -> no accept, then accept on the cycle stall drops. flush=1 during BUSY -> cnt continues, done still at T+LATENCY.
- Async reset mid-operation: nRST low in T+2 -> dec_valid=0, done=0, state IDLE immediately; after release, a matching insn is accepted with bubble_req=0.
